serial_add_sched: RTL and testbench
===================================

# serial_add_sched

Round-robin scheduler and sequencer that shares one bit-serial adder datapath (full adder, carry flop, operand shift registers, result shift register) among `NREQ` requesters. Each requester presents two `N`-bit operands with a level request. The block grants one requester at a time, loads its operands, runs `N` serial add cycles LSB-first, and returns the `N`-bit sum plus carry-out on a shared result bus with a one-cycle acknowledge. It sits between client blocks and the single serial adder resource.

## Interface
- `N`, default 4: operand and sum width; must be ≥ 2.
- `NREQ`, default 4: number of requesters; must be ≥ 2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in `NREQ`: per-requester level request.
- `a_in` in `NREQ*N`: operand A; requester i occupies bits `[i*N +: N]`.
- `b_in` in `NREQ*N`: operand B; same packing as `a_in`.
- `gnt` out `NREQ`: one-hot grant, held from load through DONE.
- `gnt_id` out `clog2(NREQ)`: binary index of the current or last grant.
- `busy` out 1: high in ADD and DONE.
- `ack` out `NREQ`: one-hot, high only in the DONE cycle, for the granted requester.
- `done` out 1: high only in the DONE cycle.
- `sum` out `N`: result; updated in the DONE cycle, held until the next DONE.
- `cout` out 1: final carry; same update and hold rule as `sum`.

## Operation
- FSM states: IDLE, ADD, DONE. State encoding lives in the package.
- IDLE
  - If `req` is nonzero: select the winner with round-robin priority, starting at `last_id+1` mod `NREQ` and searching upward with wrap.
  - At the next edge: capture the winner's A and B into the operand shift registers, clear carry, clear `cnt`, set `gnt` and `gnt_id`, set `last_id` to the winner, go to ADD.
  - If `req` is zero, stay in IDLE.
- ADD
  - Each cycle: `s = a[0]^b[0]^c`; carry ← majority(`a[0]`, `b[0]`, `c`).
  - Result register shifts right with `s` entering at the MSB. Operand registers shift right with zero fill.
  - `cnt` increments each cycle. When `cnt == N-1`, go to DONE at the next edge.
- DONE
  - `sum` ← result register, `cout` ← carry.
  - `done = 1` and `ack[gnt_id] = 1` for this one cycle.
  - At the next edge: clear `gnt` and go to IDLE.
- Arithmetic: `{cout, sum} = a + b`, computed modulo 2^(N+1), unsigned.
- Operands are sampled only at the grant edge. Changes to `a_in`/`b_in` after that edge do not affect the current add.
- Handshake: a requester holds `req` until it sees `ack`, then must deassert `req` at the edge that ends the ack cycle. If `req` is still high in the following IDLE cycle, it is treated as a new request.
- `req` changes during ADD or DONE are ignored until IDLE.
- A requester dropping `req` mid-operation does not abort the add; the result is still delivered with `ack`.
- Reset (at any time, including mid-ADD): state → IDLE, `cnt`/carry/shift registers → 0, `last_id` → `NREQ-1` so requester 0 has first priority. No `ack` is issued for the aborted operation.
- Reset values of outputs: `gnt=0`, `gnt_id=0`, `busy=0`, `ack=0`, `done=0`, `sum=0`, `cout=0`.

## Timing
- Cycle numbering: with `req` high in IDLE cycle 0:
  - cycle 1: `gnt`/`busy` high, first add step;
  - cycles 1..N: ADD;
  - cycle N+1: DONE, with `ack`, `done` and new `sum`/`cout`;
  - cycle N+2: IDLE.
- Throughput: one operation per N+2 cycles under continuous demand.
- `sum`/`cout` change only in DONE cycles, so they are stable for the ack cycle and afterwards.
- All outputs are registered except `ack`/`done`, which are decoded from the state register.

## Structure
- Package `serial_add_pkg`:
  - state enum (IDLE, ADD, DONE);
  - `ID_W = clog2(NREQ)`;
  - `CNT_W = clog2(N)`;
  - a helper function for one-hot to index conversion.
- Sub-module `rr_arbiter` (parameter `NREQ`): inputs `req` and `last_id`; outputs combinational one-hot `grant` and `grant_id`.
- The datapath (operand shifters, carry, result shifter) stays inline in `serial_add_sched`.

## Test plan
- Single add: N=4, `req[0]` with A=4'b0111, B=4'b0101 in cycle 0 → `gnt=0001` cycles 1–4, `ack[0]`/`done` in cycle 5, `sum=4'b1100`, `cout=0`.
- Carry-out: A=4'hF, B=4'h1 on requester 2 → `sum=4'h0`, `cout=1`, `gnt_id=2`, `ack=0100`.
- Contention and fairness: `req=1111` held with each requester dropping `req` after its ack → service order 0, 1, 2, 3, 0, with DONE cycles 6 apart.
- Wrap-around: after requester 3 is served, `req=1001` → requester 0 granted next.
- Reset mid-operation: assert `rst` in cycle 3 of an add → all outputs 0, no `ack`. After release with `req[1]` high → requester 1 is granted and its result is correct.
- Wide parameter: N=8, NREQ=2, A=8'hC8, B=8'h64 → `sum=8'h2C`, `cout=1`, `done` in cycle 9.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial-adder scheduler.
package serial_add_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Default geometry; instances derive their own widths from their parameters
    localparam int unsigned N_DEF    = 4;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned ID_W     = $clog2(NREQ_DEF);
    localparam int unsigned CNT_W    = $clog2(N_DEF);

    // Index of the lowest set bit of a one-hot vector (0 when empty)
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i] && idx == 0) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/serial_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_id+1 with wrap.
module rr_arbiter
    import serial_add_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned SEL_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_id,
    output logic [NREQ-1:0]  grant,
    output logic [SEL_W-1:0] grant_id
);

    // First requester at or after last_id+1 (mod NREQ) wins
    always_comb begin
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_id) + k) % NREQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign grant_id = SEL_W'(onehot_to_idx(32'(grant)));

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin sequencer sharing one bit-serial adder among NREQ requesters.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter  int unsigned N      = 4,
    parameter  int unsigned NREQ   = 4,
    localparam int unsigned SEL_W  = $clog2(NREQ),
    localparam int unsigned STEP_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*N-1:0]   a_in,
    input  logic [NREQ*N-1:0]   b_in,
    output logic [NREQ-1:0]     gnt,
    output logic [SEL_W-1:0]    gnt_id,
    output logic                busy,
    output logic [NREQ-1:0]     ack,
    output logic                done,
    output logic [N-1:0]        sum,
    output logic                cout
);

    state_t              state;
    logic [N-1:0]        a_sr;
    logic [N-1:0]        b_sr;
    logic [N-1:0]        res_sr;
    logic                carry;
    logic [STEP_W-1:0]   cnt;
    logic [SEL_W-1:0]    last_id;

    logic [NREQ-1:0]     win_gnt;
    logic [SEL_W-1:0]    win_id;
    logic [N-1:0]        win_a;
    logic [N-1:0]        win_b;
    logic                s_bit;
    logic                c_next;
    logic [N-1:0]        res_next;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req      (req),
        .last_id  (last_id),
        .grant    (win_gnt),
        .grant_id (win_id)
    );

    // Operand mux for the arbitration winner
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_gnt[i]) begin
                win_a = a_in[i*N +: N];
                win_b = b_in[i*N +: N];
            end
        end
    end

    // One full-adder step on the current LSBs
    assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign res_next = {s_bit, res_sr[N-1:1]};

    // Sequencer, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            last_id <= SEL_W'(NREQ - 1);
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        a_sr    <= win_a;
                        b_sr    <= win_b;
                        carry   <= 1'b0;
                        cnt     <= '0;
                        gnt     <= win_gnt;
                        gnt_id  <= win_id;
                        last_id <= win_id;
                        busy    <= 1'b1;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_sr   <= {1'b0, a_sr[N-1:1]};
                    b_sr   <= {1'b0, b_sr[N-1:1]};
                    res_sr <= res_next;
                    carry  <= c_next;
                    cnt    <= STEP_W'(cnt + 1'b1);
                    if (cnt == STEP_W'(N - 1)) begin
                        // Publish on entry so sum/cout are already valid in the ack cycle
                        sum   <= res_next;
                        cout  <= c_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Acknowledge strobes decoded from the state register
    assign done = (state == ST_DONE);
    assign ack  = gnt & {NREQ{done}};

endmodule

// File: tb/tb_serial_add_sched.sv
// Randomized self-checking bench for serial_add_sched (N=4/NREQ=4 and N=8/NREQ=2).
module tb_serial_add_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned NR  = 4;
    localparam int unsigned N2  = 8;
    localparam int unsigned NR2 = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*N-1:0]   a_in, b_in;
    logic [NR-1:0]     gnt, ack;
    logic [1:0]        gnt_id;
    logic              busy, done, cout;
    logic [N-1:0]      sum;

    logic [NR2-1:0]    req2;
    logic [NR2*N2-1:0] a2_in, b2_in;
    logic [NR2-1:0]    gnt2, ack2;
    logic [0:0]        gnt_id2;
    logic              busy2, done2, cout2;
    logic [N2-1:0]     sum2;

    int total = 0;
    int bad   = 0;
    int m_last;
    int m_last2;

    always #5 clk = ~clk;

    serial_add_sched #(.N(N), .NREQ(NR)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .ack(ack), .done(done),
        .sum(sum), .cout(cout)
    );

    serial_add_sched #(.N(N2), .NREQ(NR2)) dut_w (
        .clk(clk), .rst(rst), .req(req2), .a_in(a2_in), .b_in(b2_in),
        .gnt(gnt2), .gnt_id(gnt_id2), .busy(busy2), .ack(ack2), .done(done2),
        .sum(sum2), .cout(cout2)
    );

    // Reference round-robin choice: first requester after 'last', wrapping
    function automatic int rr_pick(input logic [31:0] r, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            if (r[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    // Wait (bounded) for the done strobe; cyc = negedges elapsed
    task automatic wait_done(input bit wide, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if ((wide ? done2 : done) === 1'b1) begin
                cyc = k;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req2 = '0;
        a_in = '0; b_in = '0; a2_in = '0; b2_in = '0;
        @(negedge clk); @(negedge clk);
        total++;
        if ({gnt, gnt_id, busy, ack, done, sum, cout} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%0h want=0", {gnt, gnt_id, busy, ack, done, sum, cout});
        end
        total++;
        if ({gnt2, gnt_id2, busy2, ack2, done2, sum2, cout2} !== '0) begin
            bad++; $display("FAIL reset_outputs_wide got=%0h want=0", {gnt2, gnt_id2, busy2, ack2, done2, sum2, cout2});
        end
        rst = 1'b0;
        m_last = NR - 1; m_last2 = NR2 - 1;
        @(negedge clk);
        total++;
        if ({busy, done, gnt} !== '0) begin
            bad++; $display("FAIL idle_after_reset got=%0h want=0", {busy, done, gnt});
        end
    endtask

    task automatic test_single();
        int cyc; bit to;
        a_in[0 +: N] = 4'b0111; b_in[0 +: N] = 4'b0101; req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++; $display("FAIL single_grant got gnt=%b busy=%b want gnt=0001 busy=1", gnt, busy);
        end
        wait_done(1'b0, cyc, to);
        total++;
        if (to || cyc != N) begin
            bad++; $display("FAIL single_latency got=%0d timeout=%0d want=%0d", cyc, to, N);
        end
        total++;
        if (sum !== 4'b1100 || cout !== 1'b0 || ack !== 4'b0001) begin
            bad++; $display("FAIL single_result got sum=%b cout=%b ack=%b want 1100/0/0001", sum, cout, ack);
        end
        m_last = 0;
        req = '0;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || gnt !== '0 || sum !== 4'b1100) begin
            bad++; $display("FAIL single_after got done=%b busy=%b gnt=%b sum=%b want 0/0/0000/1100", done, busy, gnt, sum);
        end
    endtask

    task automatic test_carry();
        int cyc; bit to;
        a_in[2*N +: N] = 4'hF; b_in[2*N +: N] = 4'h1; req = 4'b0100;
        @(negedge clk);
        total++;
        if (gnt_id !== 2'd2) begin
            bad++; $display("FAIL carry_gnt_id got=%0d want=2", gnt_id);
        end
        wait_done(1'b0, cyc, to);
        total++;
        if (to || sum !== 4'h0 || cout !== 1'b1 || ack !== 4'b0100) begin
            bad++; $display("FAIL carry_result got sum=%h cout=%b ack=%b to=%0d want 0/1/0100", sum, cout, ack, to);
        end
        m_last = 2;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int cyc; bit to; int w;
        logic [N:0] exp;
        for (int it = 0; it < 25; it++) begin
            a_in = 16'($urandom); b_in = 16'($urandom);
            req  = 4'($urandom_range(1, 15));
            w    = rr_pick(32'(req), m_last, NR);
            exp  = (N+1)'(a_in[w*N +: N]) + (N+1)'(b_in[w*N +: N]);
            @(negedge clk);
            total++;
            if (gnt_id !== 2'(w) || gnt !== NR'(1 << w) || busy !== 1'b1) begin
                bad++; $display("FAIL rand_grant it=%0d got id=%0d gnt=%b busy=%b want id=%0d", it, gnt_id, gnt, busy, w);
            end
            // Post-grant operand and request changes must not matter
            a_in = 16'($urandom); b_in = 16'($urandom); req = 4'($urandom);
            wait_done(1'b0, cyc, to);
            total++;
            if (to || cyc != N || {cout, sum} !== exp || ack !== NR'(1 << w)) begin
                bad++; $display("FAIL rand_result it=%0d got=%h ack=%b cyc=%0d want=%h ack_id=%0d", it, {cout, sum}, ack, cyc, exp, w);
            end
            m_last = w;
            req = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_contention();
        int cyc; bit to; int w;
        logic [N:0] exp;
        a_in = 16'($urandom); b_in = 16'($urandom);
        req  = 4'hF;
        for (int op = 0; op < 5; op++) begin
            w   = rr_pick(32'(req), m_last, NR);
            exp = (N+1)'(a_in[w*N +: N]) + (N+1)'(b_in[w*N +: N]);
            wait_done(1'b0, cyc, to);
            total++;
            if (to || cyc != ((op == 0) ? N + 1 : N + 2)) begin
                bad++; $display("FAIL contention_spacing op=%0d got=%0d want=%0d", op, cyc, (op == 0) ? N + 1 : N + 2);
            end
            total++;
            if (gnt_id !== 2'(w) || ack !== NR'(1 << w) || {cout, sum} !== exp) begin
                bad++; $display("FAIL contention_order op=%0d got id=%0d res=%h want id=%0d res=%h", op, gnt_id, {cout, sum}, w, exp);
            end
            m_last = w;
            req[w] = 1'b0;
            if (req == '0) req = 4'hF;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int cyc; bit to;
        logic [NR-1:0] masks [2];
        int want [2];
        masks[0] = 4'b1000; masks[1] = 4'b1001;
        want[0]  = 3;       want[1]  = 0;
        a_in = 16'($urandom); b_in = 16'($urandom);
        for (int op = 0; op < 2; op++) begin
            req = masks[op];
            wait_done(1'b0, cyc, to);
            total++;
            if (to || gnt_id !== 2'(want[op]) || rr_pick(32'(masks[op]), m_last, NR) != want[op]) begin
                bad++; $display("FAIL wrap op=%0d got id=%0d to=%0d want=%0d", op, gnt_id, to, want[op]);
            end
            m_last = want[op];
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc; bit to; bit saw_done;
        logic [N:0] exp;
        a_in = 16'($urandom); b_in = 16'($urandom);
        req = 4'b0100;
        saw_done = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        rst = 1'b1;
        #1;
        total++;
        if ({gnt, gnt_id, busy, ack, done, sum, cout} !== '0 || saw_done) begin
            bad++; $display("FAIL reset_mid_outputs got=%0h early_done=%0d want=0", {gnt, gnt_id, busy, ack, done, sum, cout}, saw_done);
        end
        req = 4'b0010;
        a_in = 16'($urandom); b_in = 16'($urandom);
        exp = (N+1)'(a_in[1*N +: N]) + (N+1)'(b_in[1*N +: N]);
        @(negedge clk);
        total++;
        if (ack !== '0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_mid_noack got ack=%b done=%b want 0", ack, done);
        end
        rst = 1'b0;
        m_last = NR - 1; m_last2 = NR2 - 1;
        wait_done(1'b0, cyc, to);
        total++;
        if (to || cyc != N + 1 || gnt_id !== 2'(rr_pick(32'(4'b0010), m_last, NR)) || {cout, sum} !== exp) begin
            bad++; $display("FAIL reset_mid_recover got id=%0d res=%h cyc=%0d want id=1 res=%h", gnt_id, {cout, sum}, cyc, exp);
        end
        m_last = 1;
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_wide();
        int cyc; bit to; int w;
        logic [N2:0] exp;
        a2_in[0 +: N2] = 8'hC8; b2_in[0 +: N2] = 8'h64; req2 = 2'b01;
        wait_done(1'b1, cyc, to);
        total++;
        if (to || cyc != 9 || sum2 !== 8'h2C || cout2 !== 1'b1 || ack2 !== 2'b01 || gnt_id2 !== 1'b0) begin
            bad++; $display("FAIL wide_fixed got sum=%h cout=%b ack=%b cyc=%0d want 2c/1/01/9", sum2, cout2, ack2, cyc);
        end
        m_last2 = 0;
        req2 = '0;
        @(negedge clk);
        for (int it = 0; it < 8; it++) begin
            a2_in = 16'($urandom); b2_in = 16'($urandom);
            req2  = 2'($urandom_range(1, 3));
            w     = rr_pick(32'(req2), m_last2, NR2);
            exp   = (N2+1)'(a2_in[w*N2 +: N2]) + (N2+1)'(b2_in[w*N2 +: N2]);
            wait_done(1'b1, cyc, to);
            total++;
            if (to || cyc != N2 + 1 || gnt_id2 !== 1'(w) || {cout2, sum2} !== exp) begin
                bad++; $display("FAIL wide_rand it=%0d got id=%0d res=%h cyc=%0d want id=%0d res=%h", it, gnt_id2, {cout2, sum2}, cyc, w, exp);
            end
            m_last2 = w;
            req2 = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_random();
        test_contention();
        test_wrap();
        test_reset_mid();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
